rx_address_parser: RTL and testbench

//  Receive-side counterpart of the transmitter address register. Sits on the MAC RX
//  AXI4-Stream byte interface and captures dst/src MAC addresses from each frame's

---
 rtl/eth_pkg.sv | 10 +
 rtl/rx_address_parser.sv | 87 ++++++++
 tb/tb_rx_address_parser.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet RX types, header constants and parser state encoding
package eth_pkg;
  typedef struct packed {
    logic [47:0] src;
    logic [47:0] dst;
  } address;
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
  localparam int HDR_BYTES = 12;
  typedef enum logic [1:0] {SYNC, HDR, BODY} rx_parse_state_e;
endpackage

// File: rtl/rx_address_parser.sv
// rx_address_parser: captures dst/src MACs from RX AXI4-Stream frames, strobes good frames
// Optional station-address filtering is compiled in with RX_ADDR_FILTER_EN.
module rx_address_parser
  import eth_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output address           rx_address,
  output logic             address_wr,
  output logic             runt_err,
  output logic             bad_frame,
  output logic             filt_drop,
  output logic [CNT_W-1:0] good_cnt
);
  localparam logic [3:0] LAST_HDR = 4'(HDR_BYTES - 1);
  localparam logic [3:0] DST_END  = 4'(HDR_BYTES / 2);
  rx_parse_state_e state;
  logic [3:0]  cnt;
  logic [47:0] shadow_dst, shadow_src;
  logic        accept;
`ifdef RX_ADDR_FILTER_EN
  function automatic logic addr_ok(input logic [47:0] d);
    return (d == LOCAL_MAC) || (d == MAC_BCAST) || d[40];
  endfunction
  assign accept = addr_ok(shadow_dst);
`else
  logic unused_local_mac;
  assign unused_local_mac = ^LOCAL_MAC;
  assign accept = 1'b1;
  assign filt_drop = 1'b0;
`endif
  wire eof = s_axis_tvalid && s_axis_tlast;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SYNC;
      cnt        <= '0;
      shadow_dst <= '0;
      shadow_src <= '0;
      rx_address <= '0;
      address_wr <= 1'b0;
      runt_err   <= 1'b0;
      bad_frame  <= 1'b0;
`ifdef RX_ADDR_FILTER_EN
      filt_drop  <= 1'b0;
`endif
      good_cnt   <= '0;
    end else begin
      address_wr <= 1'b0;
      runt_err   <= 1'b0;
      bad_frame  <= 1'b0;
`ifdef RX_ADDR_FILTER_EN
      filt_drop  <= 1'b0;
`endif
      case (state)
        SYNC: if (!s_axis_tvalid || s_axis_tlast) state <= HDR;
        HDR: if (s_axis_tvalid) begin
          if (cnt < DST_END) shadow_dst <= {shadow_dst[39:0], s_axis_tdata};
          else shadow_src <= {shadow_src[39:0], s_axis_tdata};
          cnt      <= (s_axis_tlast || cnt == LAST_HDR) ? 4'd0 : cnt + 4'd1;
          runt_err <= s_axis_tlast;
          if (!s_axis_tlast && cnt == LAST_HDR) state <= BODY;
        end
        BODY: if (eof) begin
          state     <= HDR;
          bad_frame <= s_axis_tuser;
          // shadow regs are copied on the tlast edge, so a following header cannot corrupt them
          if (!s_axis_tuser && accept) begin
            rx_address <= '{src: shadow_src, dst: shadow_dst};
            address_wr <= 1'b1;
            good_cnt   <= good_cnt + CNT_W'(good_cnt != '1);
          end
`ifdef RX_ADDR_FILTER_EN
          filt_drop <= !s_axis_tuser && !accept;
`endif
        end
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_address_parser.sv
// tb_rx_address_parser: directed frames with a scoreboard of expected strobes
module tb_rx_address_parser;
  import eth_pkg::*;
  localparam int CW = 2;
  localparam logic [47:0] LM = 48'h02_00_00_00_00_01;
  typedef struct {
    logic [1:0]  kind;
    logic [95:0] addr;
    logic [95:0] cnt;
    int          cyc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tdata = '0;
  logic tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  address rx_address;
  logic address_wr, runt_err, bad_frame, filt_drop;
  logic [CW-1:0] good_cnt;
  exp_t sb[$];
  logic [95:0] m_addr = '0;
  logic [CW-1:0] m_cnt = '0;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  rx_address_parser #(.CNT_W(CW), .LOCAL_MAC(LM)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser), .rx_address(rx_address),
    .address_wr(address_wr), .runt_err(runt_err), .bad_frame(bad_frame),
    .filt_drop(filt_drop), .good_cnt(good_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic bit filt_ok(input logic [47:0] d);
`ifdef RX_ADDR_FILTER_EN
    return d == LM || d == 48'hFFFF_FFFF_FFFF || d[40];
`else
    return 1'b1;
`endif
  endfunction
  always @(negedge clk) begin
    if (address_wr || runt_err || bad_frame || filt_drop) begin
      logic [1:0] k;
      exp_t e;
      k = address_wr ? 2'd0 : runt_err ? 2'd1 : bad_frame ? 2'd2 : 2'd3;
      chk("onehot", 96'($onehot({address_wr, runt_err, bad_frame, filt_drop})), 96'd1);
      chk("expected_strobe", 96'(sb.size() != 0), 96'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("kind", 96'(k), 96'(e.kind));
        chk("cycle", 96'(cyc), 96'(e.cyc));
        chk("rx_address", rx_address, e.addr);
        chk("good_cnt", 96'(good_cnt), e.cnt);
      end
    end
  end
  task automatic idle(input int n);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                            input int len, input bit bad, input bit gap);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      if (gap && i % 5 == 3) begin
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        @(posedge clk); #1;
      end
      tvalid = 1'b1;
      tdata  = i < 6 ? dst[47-8*i -: 8] : i < 12 ? src[47-8*(i-6) -: 8] : 8'(i);
      tlast  = (i == len - 1);
      tuser  = bad && tlast;
      if (tlast) begin
        if (len <= HDR_BYTES) e.kind = 2'd1;
        else if (bad) e.kind = 2'd2;
        else if (filt_ok(dst)) begin
          e.kind = 2'd0;
          m_addr = {src, dst};
          m_cnt  = (m_cnt == '1) ? m_cnt : m_cnt + 1'b1;
        end else e.kind = 2'd3;
        e.addr = m_addr;
        e.cnt  = 96'(m_cnt);
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic stream(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      tvalid = 1'b1; tdata = 8'(i); tlast = last && (i == n - 1); tuser = 1'b0;
      @(posedge clk); #1;
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, rx_address, 96'h0);
    chk({tag, "_strobes"}, 96'({address_wr, runt_err, bad_frame, filt_drop}), 96'h0);
    chk({tag, "_cnt"}, 96'(good_cnt), 96'h0);
  endtask
  task automatic drain(input string tag);
    idle(3);
    chk(tag, 96'(sb.size()), 96'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    idle(2);
    send_frame(48'h00_11_22_33_44_55, 48'h66_77_88_99_AA_BB, 64, 1'b0, 1'b0);
    drain("t1_drain");
    chk("t1_dst", 96'(rx_address.dst), 96'h0011_2233_4455);
    chk("t1_src", 96'(rx_address.src), 96'h6677_8899_AABB);
    send_frame(48'hDE_AD_BE_EF_00_01, 48'h10_20_30_40_50_60, 8, 1'b0, 1'b0);
    drain("t2_drain");
    send_frame(48'hDE_AD_BE_EF_00_02, 48'h10_20_30_40_50_61, 60, 1'b1, 1'b0);
    drain("t3_drain");
    send_frame(48'hDE_AD_BE_EF_00_03, 48'h10_20_30_40_50_62, 12, 1'b1, 1'b0);
    send_frame(48'hA0_A1_A2_A3_A4_A5, 48'hB0_B1_B2_B3_B4_B5, 13, 1'b0, 1'b1);
    drain("edge_drain");
    send_frame(48'h0A_0B_0C_0D_0E_0F, 48'hC0_C1_C2_C3_C4_C5, 20, 1'b0, 1'b0);
    send_frame(48'h00_11_22_33_44_55, 48'h01_02_03_04_05_06, 20, 1'b0, 1'b0);
    drain("t4_drain");
    chk("t4_src", 96'(rx_address.src), 96'h0102_0304_0506);
    stream(5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    m_addr = '0;
    m_cnt  = '0;
    stream(2, 1'b0);
    rst_n = 1'b1;
    stream(20, 1'b1);
    idle(2);
    send_frame(48'h00_11_22_33_44_55, 48'h0F_0E_0D_0C_0B_0A, 30, 1'b0, 1'b0);
    drain("t5_drain");
    send_frame(48'h12_34_56_78_9A_BC, 48'h22_22_22_22_22_22, 20, 1'b0, 1'b0);
    send_frame(48'hFF_FF_FF_FF_FF_FF, 48'h33_33_33_33_33_33, 20, 1'b0, 1'b0);
    send_frame(48'h01_00_5E_00_00_01, 48'h44_44_44_44_44_44, 20, 1'b0, 1'b0);
    send_frame(LM, 48'h55_55_55_55_55_55, 20, 1'b0, 1'b0);
    drain("t6_drain");
    chk("final_addr", rx_address, m_addr);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
